scpu_run_ctrl: RTL

Run/step controller for the 8-bit single-cycle CPU. It sits between the host command interface and the CPU core, and gates architectural updates through a per-cycle enable. It supports free-run, N-instruction stepping, a PC breakpoint and a HALT opcode. For every retired instruction it emits a one-cycle trace strobe with the retired opcode, which the trace monitor samples.

---
 rtl/scpu_run_ctrl_if.sv | 25 ++
 rtl/scpu_run_ctrl.sv | 70 +++++++
 2 files changed

// File: rtl/scpu_run_ctrl_if.sv
// scpu_run_ctrl_if: host command, breakpoint, CPU-side and status signals of the run/step controller.
interface scpu_run_ctrl_if;
    logic        cmd_valid;
    logic        cmd_ready;
    logic [1:0]  cmd_op;
    logic [7:0]  cmd_arg;
    logic        bp_en;
    logic [7:0]  bp_addr;
    logic [7:0]  pc;
    logic [7:0]  instruction;
    logic        cpu_en;
    logic        trace_valid;
    logic [7:0]  trace_insn;
    logic        halted;
    logic [2:0]  halt_cause;
    logic [15:0] retired_cnt;
    modport master (
        output cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, pc, instruction,
        input  cmd_ready, cpu_en, trace_valid, trace_insn, halted, halt_cause, retired_cnt
    );
    modport slave (
        input  cmd_valid, cmd_op, cmd_arg, bp_en, bp_addr, pc, instruction,
        output cmd_ready, cpu_en, trace_valid, trace_insn, halted, halt_cause, retired_cnt
    );
endinterface

// File: rtl/scpu_run_ctrl.sv
// scpu_run_ctrl: run/step/breakpoint controller gating CPU commits, with retire trace and counter.
module scpu_run_ctrl (
    input  logic           clk,
    input  logic           rst_n,
    scpu_run_ctrl_if.slave bus
);
    localparam logic [7:0] HALT_OPCODE = 8'hFF;
    typedef enum logic [1:0] {S_HALTED, S_RUN, S_STEP} state_e;
    state_e      state_q, state_d;
    logic [7:0]  remain_q, remain_d;
    logic [2:0]  cause_q, cause_d;
    logic        skip_q, skip_d;
    logic [15:0] cnt_q;
    logic        tv_q;
    logic [7:0]  ti_q;
    logic        running, cmd_fire, host_halt, go, bp_hit, halt_hit, cpu_en, last_step;
    assign running   = state_q != S_HALTED;
    assign cmd_fire  = bus.cmd_valid & bus.cmd_ready;
    assign host_halt = cmd_fire & running & (bus.cmd_op == 2'd3);
    assign go        = cmd_fire & !running & ((bus.cmd_op == 2'd1) | (bus.cmd_op == 2'd2));
    // skip lets a resumed run issue the instruction sitting on the breakpoint PC
    assign bp_hit    = bus.bp_en & (bus.pc == bus.bp_addr) & !skip_q;
    assign halt_hit  = bus.instruction == HALT_OPCODE;
    assign cpu_en    = running & !host_halt & !halt_hit & !bp_hit;
    assign last_step = (state_q == S_STEP) & (remain_q == 8'd1);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state_q <= S_HALTED;
        else        state_q <= state_d;
    end
    always_comb begin
        state_d = go ? ((bus.cmd_op == 2'd1) ? S_RUN : S_STEP) :
                  (cpu_en & !last_step) ? state_q : S_HALTED;
    end
    always_comb begin
        bus.cmd_ready   = !running | (bus.cmd_op == 2'd3) | (bus.cmd_op == 2'd0);
        bus.cpu_en      = cpu_en;
        bus.halted      = !running;
        bus.halt_cause  = cause_q;
        bus.trace_valid = tv_q;
        bus.trace_insn  = ti_q;
        bus.retired_cnt = cnt_q;
    end
    always_comb begin
        remain_d = go ? ((bus.cmd_arg == 8'd0) ? 8'd1 : bus.cmd_arg) :
                   (cpu_en & (state_q == S_STEP)) ? remain_q - 8'd1 : remain_q;
        skip_d   = go | (skip_q & !cpu_en);
        cause_d  = !running ? cause_q :
                   host_halt ? 3'd1 :
                   halt_hit  ? 3'd4 :
                   bp_hit    ? 3'd2 :
                   last_step ? 3'd3 : cause_q;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            remain_q <= 8'd0;
            cause_q  <= 3'd0;
            skip_q   <= 1'b0;
            cnt_q    <= 16'd0;
            tv_q     <= 1'b0;
            ti_q     <= 8'd0;
        end else begin
            remain_q <= remain_d;
            cause_q  <= cause_d;
            skip_q   <= skip_d;
            cnt_q    <= cnt_q + {15'd0, cpu_en};
            tv_q     <= cpu_en;
            ti_q     <= bus.instruction;
        end
    end
endmodule
